// File: rtl/word_serializer_if.sv
// Handshake bundle between the word producer, the serializer and the UART.
// The slave side is the serializer; the master side is its environment.
interface word_serializer_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic [N-1:0] in_word;
  logic         in_ready;
  logic         is_transmitting;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         done;

  modport master (
    output in_valid, in_word, is_transmitting,
    input  in_ready, tx_byte, tx_valid, done
  );

  modport slave (
    input  in_valid, in_word, is_transmitting,
    output in_ready, tx_byte, tx_valid, done
  );
endinterface

// File: rtl/word_serializer.sv
// Splits an N-bit word into an optional header, N/8 data bytes and an
// optional XOR checksum, pacing each byte by the UART busy flag.
module word_serializer #(
  parameter int         N         = 16,
  parameter bit         LSB_FIRST = 1'b0,
  parameter bit         HDR_EN    = 1'b1,
  parameter logic [7:0] HDR_BYTE  = 8'h7E,
  parameter bit         CSUM_EN   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  word_serializer_if.slave  bus
);

  localparam int NB  = N / 8;
  localparam int HB  = HDR_EN ? 1 : 0;
  localparam int CB  = CSUM_EN ? 1 : 0;
  localparam int LEN = HB + NB + CB;
  localparam int IW  = $clog2(NB + 2);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  word_q;
  logic [7:0]    csum_q;
  logic [7:0]    byte_q;
  logic [IW-1:0] idx_q;
  logic [3:0]    tmo_q;
  logic          done_q;

  logic [7:0]    cur;
  logic [7:0]    bytes [NB];
  logic          is_data;
  logic          last;
  logic          take;
  int            d;

  // Data bytes reordered so that entry 0 is always the first sent
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      if (LSB_FIRST)
        bytes[i] = word_q[8*i +: 8];
      else
        bytes[i] = word_q[N-8-8*i +: 8];
    end
  end

  always_comb begin
    d       = int'(idx_q) - HB;
    is_data = (d >= 0) && (d < NB);
    last    = (int'(idx_q) == LEN - 1);
    cur     = csum_q;
    if (HDR_EN && idx_q == '0) begin
      cur = HDR_BYTE;
    end else if (is_data) begin
      for (int i = 0; i < NB; i++)
        if (d == i) cur = bytes[i];
    end
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          take     = 1'b1;
          state_nx = STROBE;
        end
      end
      STROBE: state_nx = WAIT_HI;
      WAIT_HI: begin
        // Timeout keeps a UART that never raises busy from stalling us
        if (bus.is_transmitting || tmo_q == 4'd14)
          state_nx = WAIT_LO;
      end
      WAIT_LO: begin
        if (!bus.is_transmitting)
          state_nx = last ? IDLE : STROBE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      word_q <= '0;
      csum_q <= '0;
      byte_q <= '0;
      idx_q  <= '0;
      tmo_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == WAIT_LO) && (state_nx == IDLE);
      if (take) begin
        word_q <= bus.in_word;
        csum_q <= '0;
        idx_q  <= '0;
      end
      if (state == STROBE) begin
        byte_q <= cur;
        tmo_q  <= '0;
        if (is_data) csum_q <= csum_q ^ cur;
      end
      if (state == WAIT_HI)
        tmo_q <= tmo_q + 4'd1;
      if (state == WAIT_LO && !bus.is_transmitting && !last)
        idx_q <= idx_q + 1'b1;
    end
  end

  assign bus.in_ready = (state == IDLE) && !rst;
  assign bus.tx_valid = (state == STROBE);
  assign bus.tx_byte  = (state == STROBE) ? cur : byte_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench: three serializer configurations driven by a simple
// UART busy model, frames collected per instance and compared to constants.
module tb_word_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mute = 1'b0;
  always #5 clk = ~clk;

  word_serializer_if #(.N(16)) ia ();
  word_serializer_if #(.N(16)) ib ();
  word_serializer_if #(.N(32)) ic ();

  word_serializer #(.N(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );
  word_serializer #(.N(16), .LSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );
  word_serializer #(
    .N(32), .HDR_EN(1'b0), .CSUM_EN(1'b0)
  ) dut_c (
    .clk(clk), .rst(rst), .bus(ic)
  );

  // UART model: busy for 3 cycles after each strobe unless muted
  int cnt_a, cnt_b, cnt_c;
  always @(posedge clk) begin
    if (rst) begin
      cnt_a <= 0; cnt_b <= 0; cnt_c <= 0;
    end else begin
      if (ia.tx_valid && !mute) cnt_a <= 3;
      else if (cnt_a > 0) cnt_a <= cnt_a - 1;
      if (ib.tx_valid && !mute) cnt_b <= 3;
      else if (cnt_b > 0) cnt_b <= cnt_b - 1;
      if (ic.tx_valid && !mute) cnt_c <= 3;
      else if (cnt_c > 0) cnt_c <= cnt_c - 1;
    end
  end
  assign ia.is_transmitting = (cnt_a != 0);
  assign ib.is_transmitting = (cnt_b != 0);
  assign ic.is_transmitting = (cnt_c != 0);

  logic [7:0] qa[$], qb[$], qc[$];
  int dn_a = 0;
  always @(negedge clk) begin
    if (ia.tx_valid) qa.push_back(ia.tx_byte);
    if (ib.tx_valid) qb.push_back(ib.tx_byte);
    if (ic.tx_valid) qc.push_back(ic.tx_byte);
    if (ia.done) dn_a++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(int which, int s);
    logic [31:0] r;
    logic [7:0]  b;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      b = 8'h00;
      case (which)
        0: if (s + i < qa.size()) b = qa[s+i];
        1: if (s + i < qb.size()) b = qb[s+i];
        default: if (s + i < qc.size()) b = qc[s+i];
      endcase
      r = {r[23:0], b};
    end
    return r;
  endfunction

  function automatic logic done_of(int which);
    case (which)
      0: return ia.done;
      1: return ib.done;
      default: return ic.done;
    endcase
  endfunction

  task automatic wait_done(input int which, input int budget,
                           output int cyc);
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done_of(which)) begin
        cyc = i;
        return;
      end
    end
    check("done_timeout", {31'd0, done_of(which)}, 32'd1);
  endtask

  // Present one word from an idle cycle, then scramble in_word
  task automatic send(input int which, input logic [31:0] w);
    @(negedge clk);
    case (which)
      0: begin ia.in_valid = 1'b1; ia.in_word = w[15:0]; end
      1: begin ib.in_valid = 1'b1; ib.in_word = w[15:0]; end
      default: begin ic.in_valid = 1'b1; ic.in_word = w; end
    endcase
    @(posedge clk);
    #1;
    ia.in_valid = 1'b0; ia.in_word = 16'hFFFF;
    ib.in_valid = 1'b0; ib.in_word = 16'hFFFF;
    ic.in_valid = 1'b0; ic.in_word = 32'hFFFF_FFFF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int s, s2, d0, cyc, n;

  initial begin
    ia.in_valid = 1'b0; ia.in_word = '0;
    ib.in_valid = 1'b0; ib.in_word = '0;
    ic.in_valid = 1'b0; ic.in_word = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ia.in_ready}, 32'd0);
    check("rst_txv", {31'd0, ia.tx_valid}, 32'd0);
    check("rst_done", {31'd0, ia.done}, 32'd0);
    check("rst_byte", {24'd0, ia.tx_byte}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, ia.in_ready}, 32'd1);

    // MSB-first default frame
    s = qa.size(); d0 = dn_a;
    send(0, 32'hA55A);
    @(negedge clk);
    check("lat_txv", {31'd0, ia.tx_valid}, 32'd1);
    check("lat_byte", {24'd0, ia.tx_byte}, 32'h7E);
    wait_done(0, 200, cyc);
    check("a_ready_done", {31'd0, ia.in_ready}, 32'd1);
    @(negedge clk);
    check("a_done_1cyc", {31'd0, ia.done}, 32'd0);
    check("a_len", qa.size() - s, 32'd4);
    check("a_frame", pack(0, s), 32'h7EA55AFF);
    check("a_done_cnt", dn_a - d0, 32'd1);

    // LSB-first
    s = qb.size();
    send(1, 32'hA55A);
    wait_done(1, 200, cyc);
    @(negedge clk);
    check("b_len", qb.size() - s, 32'd4);
    check("b_frame", pack(1, s), 32'h7E5AA5FF);

    // Bare 32-bit frame
    s = qc.size();
    send(2, 32'h01020304);
    wait_done(2, 200, cyc);
    @(negedge clk);
    check("c_len", qc.size() - s, 32'd4);
    check("c_frame", pack(2, s), 32'h01020304);

    // UART never busy: each byte costs 1 + 15 + 1 cycles
    mute = 1'b1;
    s = qa.size();
    send(0, 32'h1234);
    wait_done(0, 300, cyc);
    check("tmo_cycles", cyc, 32'd69);
    @(negedge clk);
    check("tmo_frame", pack(0, s), 32'h7E123426);
    mute = 1'b0;

    // Reset in the second byte's WAIT_LO
    s = qa.size();
    send(0, 32'hA55A);
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge clk);
      if (ia.tx_valid) n++;
    end
    check("rst_reach", n, 32'd2);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_txv", {31'd0, ia.tx_valid}, 32'd0);
    check("arst_byte", {24'd0, ia.tx_byte}, 32'd0);
    check("arst_done", {31'd0, ia.done}, 32'd0);
    check("arst_ready", {31'd0, ia.in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    s2 = qa.size();
    repeat (10) @(negedge clk);
    check("arst_partial", s2 - s, 32'd2);
    check("arst_no_tx", qa.size() - s2, 32'd0);
    s = qa.size();
    send(0, 32'h1234);
    wait_done(0, 200, cyc);
    @(negedge clk);
    check("arst_fresh", pack(0, s), 32'h7E123426);

    // Back-to-back words with in_valid held high
    s = qa.size(); d0 = dn_a;
    @(negedge clk);
    ia.in_valid = 1'b1; ia.in_word = 16'h1234;
    @(posedge clk);
    #1 ia.in_word = 16'hABCD;
    @(negedge clk);
    check("b2b_hold", {31'd0, ia.in_ready}, 32'd0);
    wait_done(0, 200, cyc);
    check("b2b_ready", {31'd0, ia.in_ready}, 32'd1);
    @(posedge clk);
    #1 ia.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_lat", {31'd0, ia.tx_valid}, 32'd1);
    wait_done(0, 200, cyc);
    repeat (2) @(negedge clk);
    check("b2b_len", qa.size() - s, 32'd8);
    check("b2b_f1", pack(0, s), 32'h7E123426);
    check("b2b_f2", pack(0, s + 4), 32'h7EABCD66);
    check("b2b_dones", dn_a - d0, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the input word width in bits; N SHALL be a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter LSB_FIRST, default 0; 0 sends the most significant byte first, 1 sends the least significant byte first.
REQ-003 The block SHALL have parameter HDR_EN, default 1; 1 prepends one header byte per frame.
REQ-004 The block SHALL have parameter HDR_BYTE, default 8'h7E, giving the header byte value.
REQ-005 The block SHALL have parameter CSUM_EN, default 1; 1 appends one checksum byte per frame.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 Port in_valid, input, 1 bit: in_word is valid.
REQ-009 Port in_word, input, N bits: the word to transmit.
REQ-010 Port in_ready, output, 1 bit: the block can accept a word.
REQ-011 Port is_transmitting, input, 1 bit: busy flag from the UART transmitter.
REQ-012 Port tx_byte, output, 8 bits: byte presented to the UART.
REQ-013 Port tx_valid, output, 1 bit: one-cycle transmit strobe to the UART.
REQ-014 Port done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-015 The block SHALL use four states: IDLE, STROBE, WAIT_HI, WAIT_LO.
REQ-016 A frame SHALL consist of the header (if HDR_EN), then N/8 data bytes in the order set by LSB_FIRST, then the checksum (if CSUM_EN).
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 An in_valid && in_ready cycle SHALL capture in_word into an internal register, clear the checksum and byte index, and enter STROBE on the next edge.
REQ-019 While a frame is in progress, in_word changes SHALL NOT affect the bytes sent.
REQ-020 In STROBE, tx_valid SHALL be 1 for exactly one cycle with tx_byte holding the current frame byte; the next state is WAIT_HI.
REQ-021 tx_byte SHALL hold its value from STROBE until the next STROBE or IDLE entry.
REQ-022 In WAIT_HI, the block SHALL stay until is_transmitting is 1, then go to WAIT_LO.
REQ-023 WAIT_HI SHALL have a 15-cycle timeout; if it expires, the block treats the byte as sent and goes to WAIT_LO, so the UART's start latency cannot deadlock it.
REQ-024 In WAIT_LO, the block SHALL stay until is_transmitting is 0, then advance the byte index.
REQ-025 On leaving WAIT_LO, if the frame has more bytes the block SHALL go to STROBE; otherwise it SHALL go to IDLE and pulse done for one cycle.
REQ-026 The checksum SHALL be the XOR of the N/8 data bytes only (header excluded), 8 bits wide, updated as each data byte is strobed.
REQ-027 The byte index SHALL be sized ceil(log2(N/8+2)) bits and SHALL never wrap within a frame.
REQ-028 With HDR_EN=0 and CSUM_EN=0, the frame SHALL be exactly N/8 bytes.
REQ-029 A word presented while not in IDLE SHALL be held off (in_ready=0) and SHALL NOT be dropped or partially captured.
REQ-030 When done pulses, in_ready SHALL be 1 in the same cycle, and a new word SHALL be accepted that cycle if in_valid=1.
REQ-031 The frame latency SHALL be one cycle from capture to the first tx_valid.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, tx_byte=0, tx_valid=0, done=0, checksum=0, byte index=0, and the word register to 0.
REQ-033 While rst=1, in_ready SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no further tx_valid; the partial frame is not resumed.

Verification
REQ-035 N=16, defaults, in_word=16'hA55A, UART model busy 3 cycles after each strobe -> tx_byte sequence 7E, A5, 5A, FF, with four tx_valid pulses and one done pulse.
REQ-036 Same stimulus with LSB_FIRST=1 -> sequence 7E, 5A, A5, FF.
REQ-037 HDR_EN=0, CSUM_EN=0, N=32, in_word=32'h01020304 -> sequence 01, 02, 03, 04 and done after the 4th WAIT_LO exit.
REQ-038 is_transmitting held 0 forever -> each byte advances after the 15-cycle WAIT_HI timeout and the frame completes.
REQ-039 rst pulsed during the second byte's WAIT_LO -> outputs return to reset values asynchronously, no further tx_valid occurs, and the next word starts a fresh frame beginning with 7E.
REQ-040 in_valid held 1 with two back-to-back words (1234, then ABCD) -> the second is captured in the done cycle, and the frames are 7E 12 34 26 and 7E AB CD 66.
